// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the handshake FSM encoding and the counter-width helper.
package seq_mul_pkg;

   localparam int DEFAULT_N = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count 0..value-1; value >= 2 keeps the result >= 1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One radix-2 shift-add step of the sequential multiplier (combinational).
// Kept separate so a wider-radix step can replace it without touching the FSM.
module seq_mul_step #(
   parameter int N = 24
) (
   input  logic [N:0]   acc,
   input  logic [N-1:0] b_r,
   input  logic [N-1:0] a_r,
   input  logic         sgn_r,
   input  logic         last,
   output logic [N:0]   acc_next,
   output logic [N-1:0] b_next
);

   logic [N+1:0] acc_ext;
   logic [N+1:0] a_ext;
   logic [N+1:0] sum;

   always_comb begin
      acc_ext = sgn_r ? {acc[N], acc} : {1'b0, acc};
      a_ext   = sgn_r ? {{2{a_r[N-1]}}, a_r} : {2'b00, a_r};
      if (!b_r[0]) begin
         sum = acc_ext;
      end else if (sgn_r && last) begin
         // The multiplier MSB carries weight -2^(N-1) in two's complement.
         sum = acc_ext - a_ext;
      end else begin
         sum = acc_ext + a_ext;
      end
      acc_next = sum[N+1:1];
      b_next   = {sum[0], b_r[N-1:1]};
   end

endmodule

// File: rtl/seq_multiplier_hs.sv
// Radix-2 sequential multiplier with valid/ready handshakes on operands and product.
// Takes exactly N compute cycles; the product is held until the consumer accepts it.
module seq_multiplier_hs
   import seq_mul_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] p,
   output logic           busy
);

   localparam int CW = clog2(N);

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [N:0]       acc_reg, acc_next;
   logic [N-1:0]     a_reg, a_next;
   logic [N-1:0]     b_reg, b_next;
   logic             sgn_reg, sgn_next;
   logic [2*N-1:0]   p_reg, p_next;

   logic [N:0]       step_acc;
   logic [N-1:0]     step_b;
   logic             last;

   assign last = (count_reg == CW'(N - 1));

   seq_mul_step #(.N(N)) u_step (
      .acc      (acc_reg),
      .b_r      (b_reg),
      .a_r      (a_reg),
      .sgn_r    (sgn_reg),
      .last     (last),
      .acc_next (step_acc),
      .b_next   (step_b)
   );

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      acc_next   = acc_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sgn_next   = sgn_reg;
      p_next     = p_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               sgn_next   = is_signed;
               acc_next   = '0;
               count_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next = step_acc;
            b_next   = step_b;
            if (last) begin
               p_next     = {step_acc[N-1:0], step_b};
               state_next = DONE;
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         acc_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sgn_reg   <= 1'b0;
         p_reg     <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         acc_reg   <= acc_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sgn_reg   <= sgn_next;
         p_reg     <= p_next;
      end
   end

   // Handshake outputs come straight from the state register.
   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign p         = p_reg;

endmodule
